// File: rtl/svnseg_pkg.sv
// rtl/svnseg_pkg.sv - shared constants and segment decode for the seven-segment capture block
// Purpose: segment pattern table (active-high, bit 6 = segment a .. bit 0 = segment g),
//          inverse lookup function and bus geometry constants.
// Ports:   none (package).
package svnseg_pkg;

  localparam int NUM_DIGITS = 4;
  // Sampled bus: {dig4..dig1, seg0..seg6, seg7}
  localparam int BUS_W = NUM_DIGITS + 8;

  localparam logic [6:0] SVN_PATTERN [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  function automatic void svn_decode(input logic [6:0] pat, output logic hit, output logic [3:0] val);
    hit = 1'b0;
    val = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (!hit && pat == SVN_PATTERN[i]) begin
        hit = 1'b1;
        val = 4'(i);
      end
    end
  endfunction

endpackage

// File: rtl/svnseg_sync_settle.sv
// rtl/svnseg_sync_settle.sv - input synchronizer with settle counter and one-shot capture pulse
// Purpose: synchronizes a WIDTH-bit bus through STAGES flops, counts consecutive identical
//          samples and fires one capture pulse per stable dwell when the caller accepts it.
// Ports:   clk, rst      clock, async active-high reset
//          din[WIDTH]    raw bus
//          accept        caller qualifier for the current sample (e.g. legal digit select)
//          smp[WIDTH]    synchronized sample
//          capture       one-cycle pulse: sample settled, armed and accepted
module svnseg_sync_settle #(
  parameter int WIDTH  = 12,
  parameter int STAGES = 2,
  parameter int SETTLE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             accept,
  output logic [WIDTH-1:0] smp,
  output logic             capture
);

  localparam int CW = $clog2(SETTLE + 1);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] smp_prev;
  logic [CW-1:0]    stable_cnt;
  logic             armed;
  logic             same;

  assign smp  = sync_q[STAGES-1];
  assign same = (smp == smp_prev);
  // Requiring 'same' keeps a sample that changes in the trigger cycle from being captured.
  assign capture = armed && same && accept && (stable_cnt == CW'(SETTLE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Idle bus is all-high: blank display, no digit selected.
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '1;
      smp_prev   <= '1;
      stable_cnt <= '0;
      armed      <= 1'b1;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      smp_prev <= smp;
      if (!same) begin
        stable_cnt <= '0;
        armed      <= 1'b1;
      end else begin
        if (stable_cnt != CW'(SETTLE)) stable_cnt <= stable_cnt + CW'(1);
        if (capture) armed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/svnseg_capture.sv
// rtl/svnseg_capture.sv - receive side of the multiplexed 4-digit seven-segment bus
// Purpose: samples active-low digit selects and segments, waits for each dwell to settle,
//          decodes the pattern back to a nibble per digit and reports frame/valid/error status.
// Ports:   clk, rst          clock, async active-high reset
//          dig1..dig4        active-low digit selects (dig1 = num0)
//          seg0..seg6        active-low segment bits 6..0; seg7 active-low decimal point
//          num0..num3        last good decoded value per digit
//          dp[4]             decimal point per digit, active-high
//          valid             full frame seen and no timeout since
//          frame_strobe      one-cycle pulse on frame completion
//          err[4]            sticky per-digit undecodable pattern flag
module svnseg_capture
  import svnseg_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dig1,
  input  logic       dig2,
  input  logic       dig3,
  input  logic       dig4,
  input  logic       seg0,
  input  logic       seg1,
  input  logic       seg2,
  input  logic       seg3,
  input  logic       seg4,
  input  logic       seg5,
  input  logic       seg6,
  input  logic       seg7,
  output logic [3:0] num3,
  output logic [3:0] num2,
  output logic [3:0] num1,
  output logic [3:0] num0,
  output logic [3:0] dp,
  output logic       valid,
  output logic       frame_strobe,
  output logic [3:0] err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [BUS_W-1:0]      bus;
  logic [BUS_W-1:0]      smp;
  logic                  capture;
  logic [NUM_DIGITS-1:0] sel;
  logic                  sel_ok;
  logic [6:0]            pat;
  logic                  dp_bit;
  logic                  hit;
  logic [3:0]            val;
  logic [NUM_DIGITS-1:0] seen;
  logic [NUM_DIGITS-1:0] seen_next;
  logic                  frame;
  logic                  timeout_hit;
  logic [TW-1:0]         timeout_cnt;
  logic [3:0]            num_r [NUM_DIGITS];

  assign bus = {dig4, dig3, dig2, dig1, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7};

  svnseg_sync_settle #(
    .WIDTH (BUS_W),
    .STAGES(SYNC_STAGES),
    .SETTLE(SETTLE_CYCLES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (bus),
    .accept (sel_ok),
    .smp    (smp),
    .capture(capture)
  );

  // One-hot digit select after inversion; blank and multi-select are both rejected.
  assign sel    = ~smp[BUS_W-1 -: NUM_DIGITS];
  assign sel_ok = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  assign pat    = ~smp[7:1];
  assign dp_bit = ~smp[0];

  always_comb begin
    hit = 1'b0;
    val = 4'd0;
    svn_decode(pat, hit, val);
  end

  // Only a decoded digit counts toward the frame; a bad pattern leaves its seen bit alone.
  assign seen_next   = seen | (hit ? sel : '0);
  assign frame       = capture && sel[NUM_DIGITS-1] && (seen_next == '1);
  assign timeout_hit = (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) num_r[i] <= 4'd0;
      dp           <= '0;
      err          <= '0;
      seen         <= '0;
      valid        <= 1'b0;
      frame_strobe <= 1'b0;
      timeout_cnt  <= '0;
    end else begin
      frame_strobe <= 1'b0;
      if (capture) begin
        // A capture in the timeout cycle wins: counter restarts, valid untouched.
        timeout_cnt <= '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel[i]) begin
            dp[i] <= dp_bit;
            if (hit) num_r[i] <= val;
            else     err[i]   <= 1'b1;
          end
        end
        if (frame) begin
          frame_strobe <= 1'b1;
          valid        <= 1'b1;
          seen         <= '0;
        end else begin
          seen <= seen_next;
        end
      end else if (timeout_hit) begin
        valid       <= 1'b0;
        seen        <= '0;
        timeout_cnt <= '0;
      end else begin
        timeout_cnt <= timeout_cnt + TW'(1);
      end
    end
  end

  assign num0 = num_r[0];
  assign num1 = num_r[1];
  assign num2 = num_r[2];
  assign num3 = num_r[3];

endmodule

// File: tb/tb_svnseg_capture.sv
// tb/tb_svnseg_capture.sv - directed scoreboard bench for svnseg_capture
module tb_svnseg_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       dig1, dig2, dig3, dig4;
  logic       seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
  logic [3:0] num3, num2, num1, num0, dp, err;
  logic       valid, frame_strobe;

  svnseg_capture #(
    .SYNC_STAGES   (2),
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(256)
  ) dut (
    .clk(clk), .rst(rst),
    .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .seg4(seg4), .seg5(seg5), .seg6(seg6), .seg7(seg7),
    .num3(num3), .num2(num2), .num1(num1), .num0(num0),
    .dp(dp), .valid(valid), .frame_strobe(frame_strobe), .err(err)
  );

  typedef struct packed {
    logic [3:0] n3, n2, n1, n0;
    logic [3:0] dp;
    logic [3:0] err;
    logic       valid;
    logic       strobe;
  } exp_t;

  // Segment encodings for 0..F, active-high, bit 6 = segment a.
  localparam logic [6:0] TBL [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  exp_t       sb [$];
  int         errors = 0;
  int         checks = 0;
  int         now_t = 0;
  int         last_cap = 0;
  logic [3:0] m_num [4];
  logic [3:0] m_dp, m_err, m_seen;
  logic       m_valid;

  function automatic exp_t observe();
    exp_t o;
    o.n3 = num3; o.n2 = num2; o.n1 = num1; o.n0 = num0;
    o.dp = dp; o.err = err; o.valid = valid; o.strobe = frame_strobe;
    return o;
  endfunction

  function automatic exp_t snap(input logic s);
    exp_t e;
    e.n3 = m_num[3]; e.n2 = m_num[2]; e.n1 = m_num[1]; e.n0 = m_num[0];
    e.dp = m_dp; e.err = m_err; e.valid = m_valid; e.strobe = s;
    return e;
  endfunction

  task automatic chk(input string tag, input exp_t o, input exp_t e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      now_t++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_num[i] = 4'd0;
    m_dp = '0; m_err = '0; m_seen = '0; m_valid = 1'b0;
  endtask

  // Returns the expected frame strobe for a capture of digit d.
  task automatic model_apply(input int d, input logic [6:0] pat, input logic dpon, output logic s);
    logic hit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!hit && TBL[i] == pat) begin
        hit = 1'b1;
        m_num[d] = 4'(i);
      end
    end
    if (hit) m_seen[d] = 1'b1;
    else     m_err[d]  = 1'b1;
    m_dp[d] = dpon;
    s = (d == 3) && (m_seen == 4'hF);
    if (s) begin
      m_valid = 1'b1;
      m_seen  = '0;
    end
  endtask

  // pat/dpon are active-high; the bus carries them inverted.
  task automatic set_pins(input logic [3:0] dsel_n, input logic [6:0] pat_n, input logic dp_n);
    {dig4, dig3, dig2, dig1} = dsel_n;
    {seg0, seg1, seg2, seg3, seg4, seg5, seg6} = pat_n;
    seg7 = dp_n;
  endtask

  task automatic capture(input int d, input logic [6:0] pat, input logic dpon, input int hold, input string tag);
    logic s;
    sb.push_back(snap(1'b0));
    model_apply(d, pat, dpon, s);
    sb.push_back(snap(s));
    sb.push_back(snap(1'b0));
    set_pins(~(4'b0001 << d), ~pat, ~dpon);
    step(6);
    chk({tag, "_pre"}, observe(), sb.pop_front());
    step(1);
    last_cap = now_t;
    chk({tag, "_cap"}, observe(), sb.pop_front());
    step(1);
    chk({tag, "_post"}, observe(), sb.pop_front());
    step(hold - 8);
  endtask

  initial begin
    rst = 1'b1;
    set_pins(4'hF, 7'h7F, 1'b1);
    model_reset();
    step(3);
    chk("reset", observe(), snap(1'b0));
    rst = 1'b0;
    step(2);
    chk("idle", observe(), snap(1'b0));

    // Full frame 1,2,3,4 with dp on the second digit only.
    capture(0, TBL[1], 1'b0, 20, "f1_d0");
    capture(1, TBL[2], 1'b1, 20, "f1_d1");
    capture(2, TBL[3], 1'b0, 20, "f1_d2");
    capture(3, TBL[4], 1'b0, 20, "f1_d3");

    // Reset in the middle of a dwell, then a fresh full settle.
    set_pins(~4'b0001, ~TBL[5], 1'b1);
    step(4);
    #2 rst = 1'b1;
    #1 model_reset();
    chk("rst_async", observe(), snap(1'b0));
    step(1);
    rst = 1'b0;
    capture(0, TBL[5], 1'b0, 20, "after_rst");

    // Glitching bus: nothing may be captured while it toggles.
    for (int k = 0; k < 15; k++) begin
      if (k % 2 == 0) set_pins(~4'b0010, ~TBL[3], 1'b0);
      else            set_pins(~4'b0100, ~TBL[9], 1'b1);
      step(2);
      chk("glitch", observe(), snap(1'b0));
    end
    capture(2, TBL[7], 1'b0, 20, "glitch_hold");

    // Illegal selects: blank then two digits low.
    set_pins(4'hF, ~TBL[8], 1'b1);
    step(50);
    chk("blank_sel", observe(), snap(1'b0));
    set_pins(4'b0101, ~TBL[5], 1'b0);
    step(50);
    chk("multi_sel", observe(), snap(1'b0));

    // Undecodable (all segments off) on digit 0, then an incomplete-frame dig4 capture.
    capture(0, 7'b0000000, 1'b0, 20, "bad_pat");
    capture(3, TBL[4], 1'b0, 20, "no_frame");

    // Timeout after a complete frame.
    capture(0, TBL[6], 1'b0, 20, "f2_d0");
    capture(1, TBL[7], 1'b0, 20, "f2_d1");
    capture(2, TBL[8], 1'b1, 20, "f2_d2");
    capture(3, TBL[9], 1'b0, 20, "f2_d3");
    set_pins(4'hF, 7'h7F, 1'b1);
    step(last_cap + 255 - now_t);
    chk("to_255", observe(), snap(1'b0));
    step(1);
    m_valid = 1'b0;
    m_seen  = '0;
    chk("to_256", observe(), snap(1'b0));

    // Captures at 255 and at 256 clocks after the previous one keep valid.
    capture(0, TBL[2], 1'b0, 20, "f3_d0");
    capture(1, TBL[3], 1'b0, 20, "f3_d1");
    capture(2, TBL[4], 1'b0, 20, "f3_d2");
    capture(3, TBL[5], 1'b1, 20, "f3_d3");
    set_pins(4'hF, 7'h7F, 1'b1);
    step(last_cap + 248 - now_t);
    capture(0, TBL[10], 1'b0, 10, "cap255");
    chk("cap255_hold", observe(), snap(1'b0));
    set_pins(4'hF, 7'h7F, 1'b1);
    step(last_cap + 249 - now_t);
    capture(1, TBL[11], 1'b1, 10, "cap256");
    chk("cap256_hold", observe(), snap(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
